// File: rtl/float_fix_pkg.sv
// Shared types and constants for the float16 -> sign-magnitude Q7.8 converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package float_fix_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        LOAD  = 3'd3,
        SHIFT = 3'd4,
        WR_LO = 3'd5,
        WR_HI = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam int FP_BIAS  = 15;
    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int FIX_FRAC = 8;

    // Exponent thresholds. An exponent of 17 puts the hidden bit at fixed bit 10,
    // which is where {1,m} already sits, so no shift is needed there.
    localparam logic [EXP_W-1:0] E_SAT         = 5'd22;
    localparam logic [EXP_W-1:0] E_ZERO_MAX    = 5'd5;
    localparam logic [EXP_W-1:0] E_UNITY_SHIFT = 5'd17;

    localparam logic [14:0] SAT_MAG = 15'h7FFF;

endpackage

// File: rtl/float_to_fix_decode.sv
// Classifies a float16 and yields the initial magnitude plus shift direction/count.
// Latency: combinational.
// Backpressure: none.
module float16_decode
    import float_fix_pkg::*;
(
    input  logic [15:0] f,
    output logic        s,
    output logic [14:0] mag_init,
    output logic        dir,      // 1 = shift left, 0 = shift right
    output logic [3:0]  n
);

    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    logic [EXP_W-1:0]  diff;

    assign s = f[15];
    assign e = f[14:10];
    assign m = f[9:0];

    // Pick magnitude seed and shift plan from the exponent range.
    always_comb begin
        mag_init = 15'd0;
        dir      = 1'b0;
        n        = 4'd0;
        diff     = 5'd0;
        if (e <= E_ZERO_MAX) begin
            // Zero, subnormals (flushed) and anything below 2^-9 truncate to 0.
            mag_init = 15'd0;
        end else if (e >= E_SAT) begin
            // Covers |x| >= 128 and inf/NaN.
            mag_init = SAT_MAG;
        end else if (e >= E_UNITY_SHIFT) begin
            diff     = e - E_UNITY_SHIFT;
            mag_init = {4'd0, 1'b1, m};
            dir      = 1'b1;
            n        = diff[3:0];
        end else begin
            diff     = E_UNITY_SHIFT - e;
            mag_init = {4'd0, 1'b1, m};
            dir      = 1'b0;
            n        = diff[3:0];
        end
    end

endmodule

// File: rtl/float_to_fix.sv
// Reads float16 at SRC_ADDR, writes sign-magnitude Q7.8 at DST_ADDR, pulses nothing but holds done.
// Latency: done rises 5+n edges after start is sampled (n = shift count, 0..11).
// Backpressure: none; start outside IDLE/DONE is ignored.
module float_to_fix
    import float_fix_pkg::*;
#(
    parameter logic [7:0] SRC_ADDR = 8'd2,
    parameter logic [7:0] DST_ADDR = 8'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    state_t      state_q, state_d;
    logic [15:0] f_q;
    logic        s_q;
    logic [14:0] mag_q;
    logic        dir_q;
    logic [3:0]  n_q;

    logic        dec_s;
    logic [14:0] dec_mag;
    logic        dec_dir;
    logic [3:0]  dec_n;

    float16_decode u_decode (
        .f        (f_q),
        .s        (dec_s),
        .mag_init (dec_mag),
        .dir      (dec_dir),
        .n        (dec_n)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RD_LO;
            RD_LO:      state_d = RD_HI;
            RD_HI:      state_d = LOAD;
            LOAD:       state_d = (dec_n != 4'd0) ? SHIFT : WR_LO;
            SHIFT:      if (n_q == 4'd1) state_d = WR_LO;
            WR_LO:      state_d = WR_HI;
            WR_HI:      state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, decode load, iterative shifter and done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_q   <= 16'd0;
            s_q   <= 1'b0;
            mag_q <= 15'd0;
            dir_q <= 1'b0;
            n_q   <= 4'd0;
            done  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) done <= 1'b0;
                RD_LO:      f_q[7:0]  <= mem_rdata;
                RD_HI:      f_q[15:8] <= mem_rdata;
                LOAD: begin
                    s_q   <= dec_s;
                    mag_q <= dec_mag;
                    dir_q <= dec_dir;
                    n_q   <= dec_n;
                end
                SHIFT: begin
                    // Right shifts drop LSBs: truncation, no rounding.
                    mag_q <= dir_q ? {mag_q[13:0], 1'b0} : {1'b0, mag_q[14:1]};
                    n_q   <= n_q - 4'd1;
                end
                WR_HI:      done <= 1'b1;
                default:    ;
            endcase
        end
    end

    // Memory port decoded from state; idle states park everything at zero.
    always_comb begin
        mem_addr  = 8'd0;
        mem_wr_en = 1'b0;
        mem_wdata = 8'd0;
        case (state_q)
            RD_LO: mem_addr = SRC_ADDR;
            RD_HI: mem_addr = SRC_ADDR + 8'd1;
            WR_LO: begin
                mem_addr  = DST_ADDR;
                mem_wr_en = 1'b1;
                mem_wdata = mag_q[7:0];
            end
            WR_HI: begin
                mem_addr  = DST_ADDR + 8'd1;
                mem_wr_en = 1'b1;
                mem_wdata = {s_q, mag_q[14:8]};
            end
            default: ;
        endcase
    end

endmodule

// File: doc/float_to_fix.md
Name: float_to_fix

Overview:
- Program 2 stage, directly downstream of the fixed-to-float converter.
- Reads the float16 that the fixed-to-float converter writes at data memory bytes [3:2].
- Converts it to 16-bit sign-magnitude fixed point: bit15 sign, bits14:0 magnitude, 8 fractional bits.
- Writes the result to bytes [5:4], then raises done to the testbench.
- Iterative: one mantissa shift per clock. No rounding; the conversion truncates.

Parameters:
- SRC_ADDR, 8'd2: address of float low byte; high byte is at SRC_ADDR+1.
- DST_ADDR, 8'd4: address of fixed-point low byte; high byte is at DST_ADDR+1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- start  input  1  request for the next conversion; one-cycle pulse
- done  output  1  result written; held until the next accepted start
- mem_addr  output  8  data memory address
- mem_wr_en  output  1  data memory write enable; write occurs at posedge
- mem_wdata  output  8  data memory write byte
- mem_rdata  input  8  data memory read byte; asynchronous, valid in the same cycle as mem_addr

Behaviour:
- Reset: state=IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, internal registers cleared.
- Reset mid-operation aborts the conversion. No further writes occur; any byte already written stays.
- States: IDLE, RD_LO, RD_HI, LOAD, SHIFT, WR_LO, WR_HI, DONE.
- IDLE/DONE: start=1 -> RD_LO and done<=0. start in any other state is ignored.
- RD_LO: mem_addr=SRC_ADDR; capture f[7:0]. -> RD_HI.
- RD_HI: mem_addr=SRC_ADDR+1; capture f[15:8]. -> LOAD.
- LOAD: s=f[15], e=f[14:10], m=f[9:0]; mag<=0 (15 bits) then, by case:
  - e==0 (zero/subnormal, flushed) or e<=5: mag=0, n=0.
  - e>=22 (covers e=31 inf/NaN): mag=15'h7FFF (saturate), n=0.
  - 17<=e<=21: mag={1,m} zero-extended, left shift, n=e-17 (0..4).
  - 6<=e<=16: mag={1,m}, right shift, n=17-e (1..11).
  - Exits to SHIFT if n>0, else WR_LO.
- SHIFT: one 1-bit shift of mag per cycle in the chosen direction.
  - Right shift discards bits (truncation).
  - Left shift never overflows, because e<=21 bounds the result at 15'h7FF0.
  - Decrement n; -> WR_LO when n reaches 1 in this cycle.
- WR_LO: mem_addr=DST_ADDR, mem_wdata=mag[7:0], mem_wr_en=1. -> WR_HI.
- WR_HI: mem_addr=DST_ADDR+1, mem_wdata={s,mag[14:8]}, mem_wr_en=1. -> DONE; done<=1.
- Sign: s is copied unchanged in all cases.
  - -0 gives 16'h8000.
  - Negative saturation gives 16'hFFFF.
- Latency: done first high 5+n clock edges after the edge that samples start. Minimum 5, maximum 16.
- mem_wr_en is high only in WR_LO and WR_HI; all memory outputs are registered/decoded from state.
- start asserted in the same cycle done rises: not accepted, because the state is WR_HI.

Decomposition:
- Package float_fix_pkg holds:
  - state enum;
  - FP_BIAS=15, EXP_W=5, MANT_W=10, FIX_FRAC=8;
  - E_SAT=22, E_ZERO_MAX=5, E_UNITY_SHIFT=17;
  - SAT_MAG=15'h7FFF.
- One combinational sub-module, float16_decode: takes f[15:0] and returns s, mag_init[14:0], dir, n[3:0]. It is used in LOAD.
- The FSM and shifter stay in float_to_fix.

Test Plan:
- mem[3:2]=16'h3C00 (1.0) -> mem[5:4]=16'h0100; done 7 edges after start.
- 16'hC100 (-2.5) -> 16'h8280; 16'h1C00 (2^-8) -> 16'h0001 (n=10); 16'h1800 (2^-9) -> 16'h0000.
- 16'h57FF (127.9375) -> 16'h7FF0 after 9 edges; 16'h5800 (128.0) -> 16'h7FFF; 16'hFC00 (-inf) -> 16'hFFFF; each saturating case in 5 edges.
- 16'h0000 -> 16'h0000 and 16'h8000 -> 16'h8000 (done at 5 edges); subnormal 16'h03FF -> 16'h0000.
- Robustness:
  - start pulsed again during SHIFT -> ignored; result and latency unchanged.
  - reset asserted in SHIFT -> done=0, no write to mem[5:4], next start converts correctly.
- Back-to-back: run the fixed-to-float converter on fixed 16'h0180 (1.5) -> float at [3:2]. Then float_to_fix -> 16'h0180 exact round-trip; done falls on start and rises again per latency.
